// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: fetches into IR, decodes the opcode and
// drives PC, data-memory, register-file and ALU controls as a Moore FSM.
module control_unit (
    input  logic        clk,
    input  logic        clear_n,
    input  logic [15:0] instr,
    output logic        pc_clr,
    output logic        pc_up,
    output logic [15:0] ir_q,
    output logic [7:0]  d_addr,
    output logic        d_wr,
    output logic        rf_s,
    output logic [3:0]  rf_w_addr,
    output logic        rf_w_en,
    output logic [3:0]  rf_ra_addr,
    output logic [3:0]  rf_rb_addr,
    output logic [2:0]  alu_s,
    output logic        halted,
    output logic [3:0]  state
);

    localparam int unsigned IW = 16;
    localparam int unsigned AW = 8;
    localparam int unsigned RW = 4;
    localparam int unsigned SW = 4;
    localparam int unsigned FW = 3;

    localparam logic [FW-1:0] ALU_ADD = FW'(1);
    localparam logic [FW-1:0] ALU_SUB = FW'(2);

    typedef enum logic [SW-1:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_e;

    state_e        state_q;
    state_e        state_d;
    logic [IW-1:0] ir_d;

    logic          pc_clr_d;
    logic          pc_up_d;
    logic [AW-1:0] d_addr_d;
    logic          d_wr_d;
    logic          rf_s_d;
    logic [RW-1:0] rf_w_addr_d;
    logic          rf_w_en_d;
    logic [RW-1:0] rf_ra_addr_d;
    logic [RW-1:0] rf_rb_addr_d;
    logic [FW-1:0] alu_s_d;
    logic          halted_d;

    // Next-state and IR capture; unused encodings fall back to INIT.
    always_comb begin
        state_d = S_INIT;
        ir_d    = ir_q;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH: begin
                ir_d    = instr;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (ir_q[15:12])
                    4'h1:    state_d = S_STORE;
                    4'h2:    state_d = S_LOAD_A;
                    4'h3:    state_d = S_ADD;
                    4'h4:    state_d = S_SUB;
                    4'h5:    state_d = S_HALT;
                    default: state_d = S_NOOP;
                endcase
            end
            S_NOOP:   state_d = S_FETCH;
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: state_d = S_FETCH;
            S_STORE:  state_d = S_FETCH;
            S_ADD:    state_d = S_FETCH;
            S_SUB:    state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies
    // line up with the state register in the same cycle.
    always_comb begin
        pc_clr_d     = 1'b0;
        pc_up_d      = 1'b0;
        d_addr_d     = '0;
        d_wr_d       = 1'b0;
        rf_s_d       = 1'b0;
        rf_w_addr_d  = '0;
        rf_w_en_d    = 1'b0;
        rf_ra_addr_d = '0;
        rf_rb_addr_d = '0;
        alu_s_d      = '0;
        halted_d     = 1'b0;
        case (state_d)
            S_INIT:  pc_clr_d = 1'b1;
            S_FETCH: pc_up_d  = 1'b1;
            S_LOAD_A, S_LOAD_B: begin
                d_addr_d    = ir_d[11:4];
                rf_s_d      = 1'b1;
                rf_w_addr_d = ir_d[3:0];
                rf_w_en_d   = (state_d == S_LOAD_B);
            end
            S_STORE: begin
                d_addr_d     = ir_d[7:0];
                rf_ra_addr_d = ir_d[11:8];
                d_wr_d       = 1'b1;
            end
            S_ADD, S_SUB: begin
                rf_ra_addr_d = ir_d[11:8];
                rf_rb_addr_d = ir_d[7:4];
                rf_w_addr_d  = ir_d[3:0];
                rf_w_en_d    = 1'b1;
                alu_s_d      = (state_d == S_ADD) ? ALU_ADD : ALU_SUB;
            end
            S_HALT:  halted_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q    <= S_INIT;
            ir_q       <= '0;
            pc_clr     <= 1'b1;
            pc_up      <= 1'b0;
            d_addr     <= '0;
            d_wr       <= 1'b0;
            rf_s       <= 1'b0;
            rf_w_addr  <= '0;
            rf_w_en    <= 1'b0;
            rf_ra_addr <= '0;
            rf_rb_addr <= '0;
            alu_s      <= '0;
            halted     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            pc_clr     <= pc_clr_d;
            pc_up      <= pc_up_d;
            d_addr     <= d_addr_d;
            d_wr       <= d_wr_d;
            rf_s       <= rf_s_d;
            rf_w_addr  <= rf_w_addr_d;
            rf_w_en    <= rf_w_en_d;
            rf_ra_addr <= rf_ra_addr_d;
            rf_rb_addr <= rf_rb_addr_d;
            alu_s      <= alu_s_d;
            halted     <= halted_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: directed instruction stream with
// hand-written per-cycle expected outputs, checked by a negedge monitor.
module tb_control_unit;

    logic        clk;
    logic        clear_n;
    logic [15:0] instr;
    logic        pc_clr;
    logic        pc_up;
    logic [15:0] ir_q;
    logic [7:0]  d_addr;
    logic        d_wr;
    logic        rf_s;
    logic [3:0]  rf_w_addr;
    logic        rf_w_en;
    logic [3:0]  rf_ra_addr;
    logic [3:0]  rf_rb_addr;
    logic [2:0]  alu_s;
    logic        halted;
    logic [3:0]  state;

    control_unit dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .instr      (instr),
        .pc_clr     (pc_clr),
        .pc_up      (pc_up),
        .ir_q       (ir_q),
        .d_addr     (d_addr),
        .d_wr       (d_wr),
        .rf_s       (rf_s),
        .rf_w_addr  (rf_w_addr),
        .rf_w_en    (rf_w_en),
        .rf_ra_addr (rf_ra_addr),
        .rf_rb_addr (rf_rb_addr),
        .alu_s      (alu_s),
        .halted     (halted),
        .state      (state)
    );

    typedef struct packed {
        logic        pc_clr;
        logic        pc_up;
        logic [15:0] ir;
        logic [7:0]  d_addr;
        logic        d_wr;
        logic        rf_s;
        logic [3:0]  wa;
        logic        wen;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [2:0]  alu;
        logic        halted;
        logic [3:0]  st;
    } out_t;

    typedef struct {
        string nm;
        out_t  v;
    } sb_t;

    sb_t sb_q[$];
    int  checks   = 0;
    int  failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mk(input logic pcc, input logic pcu, input logic [15:0] ir,
                                input logic [7:0] da, input logic dw, input logic rs,
                                input logic [3:0] wa, input logic wen, input logic [3:0] ra,
                                input logic [3:0] rb, input logic [2:0] alu, input logic hlt,
                                input logic [3:0] st);
        out_t o;
        o.pc_clr = pcc; o.pc_up = pcu; o.ir = ir; o.d_addr = da; o.d_wr = dw;
        o.rf_s = rs; o.wa = wa; o.wen = wen; o.ra = ra; o.rb = rb; o.alu = alu;
        o.halted = hlt; o.st = st;
        return o;
    endfunction

    function automatic out_t e_init();
        return mk(1, 0, 16'h0000, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 0, 4'd0);
    endfunction
    function automatic out_t e_fetch(input logic [15:0] ir);
        return mk(0, 1, ir, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 0, 4'd1);
    endfunction
    function automatic out_t e_dec(input logic [15:0] ir);
        return mk(0, 0, ir, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 0, 4'd2);
    endfunction
    function automatic out_t e_noop(input logic [15:0] ir);
        return mk(0, 0, ir, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 0, 4'd3);
    endfunction
    function automatic out_t e_halt();
        return mk(0, 0, 16'h5000, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 1, 4'd9);
    endfunction

    // Sample outputs after an edge, queue the expectation, then set inputs for the next edge.
    task automatic tick(input string nm, input logic cn, input logic [15:0] in, input out_t e);
        sb_t s;
        @(posedge clk);
        #1;
        s.nm = nm;
        s.v  = e;
        sb_q.push_back(s);
        clear_n = cn;
        instr   = in;
    endtask

    always @(negedge clk) begin
        out_t act;
        sb_t  s;
        act = {pc_clr, pc_up, ir_q, d_addr, d_wr, rf_s, rf_w_addr, rf_w_en,
               rf_ra_addr, rf_rb_addr, alu_s, halted, state};
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            checks++;
            if (act !== s.v) begin
                failures++;
                $display("FAIL %s: got %h expected %h (state got %0d exp %0d)",
                         s.nm, act, s.v, act.st, s.v.st);
            end
        end
    end

    initial begin
        clear_n = 1'b0;
        instr   = 16'h0000;

        // reset then NOOP
        tick("rst_init",  1, 16'h0000, e_init());
        tick("fetch0",    1, 16'h0000, e_fetch(16'h0000));
        tick("dec_nop",   1, 16'h0000, e_dec(16'h0000));
        tick("noop",      1, 16'h0000, e_noop(16'h0000));
        // LOAD r3 <- mem[0x12]
        tick("fetch_ld",  1, 16'h2123, e_fetch(16'h0000));
        tick("dec_ld",    1, 16'h2123, e_dec(16'h2123));
        tick("load_a",    1, 16'h2123, mk(0, 0, 16'h2123, 8'h12, 0, 1, 4'h3, 0, 4'h0, 4'h0, 3'd0, 0, 4'd4));
        tick("load_b",    1, 16'h2123, mk(0, 0, 16'h2123, 8'h12, 0, 1, 4'h3, 1, 4'h0, 4'h0, 3'd0, 0, 4'd5));
        // STORE r4 -> mem[0x05]
        tick("fetch_st",  1, 16'h1405, e_fetch(16'h2123));
        tick("dec_st",    1, 16'h1405, e_dec(16'h1405));
        tick("store",     1, 16'h1405, mk(0, 0, 16'h1405, 8'h05, 1, 0, 4'h0, 0, 4'h4, 4'h0, 3'd0, 0, 4'd6));
        // ADD then SUB r3 <- r1 op r2
        tick("fetch_add", 1, 16'h3123, e_fetch(16'h1405));
        tick("dec_add",   1, 16'h3123, e_dec(16'h3123));
        tick("add",       1, 16'h3123, mk(0, 0, 16'h3123, 8'h00, 0, 0, 4'h3, 1, 4'h1, 4'h2, 3'd1, 0, 4'd7));
        tick("fetch_sub", 1, 16'h4123, e_fetch(16'h3123));
        tick("dec_sub",   1, 16'h4123, e_dec(16'h4123));
        tick("sub",       1, 16'h4123, mk(0, 0, 16'h4123, 8'h00, 0, 0, 4'h3, 1, 4'h1, 4'h2, 3'd2, 0, 4'd8));
        // illegal opcode behaves as NOOP
        tick("fetch_ill", 1, 16'hF000, e_fetch(16'h4123));
        tick("dec_ill",   1, 16'hF000, e_dec(16'hF000));
        tick("noop_ill",  1, 16'hF000, e_noop(16'hF000));
        // reset in the middle of a LOAD
        tick("fetch_ld2", 1, 16'h2123, e_fetch(16'hF000));
        tick("dec_ld2",   1, 16'h2123, e_dec(16'h2123));
        tick("load_a_rst",0, 16'h2123, mk(0, 0, 16'h2123, 8'h12, 0, 1, 4'h3, 0, 4'h0, 4'h0, 3'd0, 0, 4'd4));
        tick("init_ld",   1, 16'h5000, e_init());
        // HALT held, then cleared
        tick("fetch_hlt", 1, 16'h5000, e_fetch(16'h0000));
        tick("dec_hlt",   1, 16'h5000, e_dec(16'h5000));
        tick("halt",      1, 16'h5000, e_halt());
        for (int i = 0; i < 20; i++)
            tick("halt_hold", (i == 19) ? 1'b0 : 1'b1, 16'h5000, e_halt());
        tick("init_hlt",  1, 16'h1405, e_init());
        // reset during STORE
        tick("fetch_st2", 1, 16'h1405, e_fetch(16'h0000));
        tick("dec_st2",   1, 16'h1405, e_dec(16'h1405));
        tick("store_rst", 0, 16'h1405, mk(0, 0, 16'h1405, 8'h05, 1, 0, 4'h0, 0, 4'h4, 4'h0, 3'd0, 0, 4'd6));
        tick("init_st",   1, 16'h0000, e_init());
        tick("fetch_end", 1, 16'h0000, e_fetch(16'h0000));

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
